golden_nonce_queue: RTL

Buffers golden nonces produced by the hashing control unit and serialises their hand-off to `serial_transmit`, so back-to-back hits are no longer lost while the UART is busy. Sits between the golden-ticket check (producer: one-cycle `in_valid` strobe plus nonce) and `serial_transmit` (consumer: `send`/`busy`/`word`). It is a synchronous FIFO with a small transmit-handshake state machine, all in the `hash_clk` domain.

---
 rtl/golden_nonce_queue.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/golden_nonce_queue.sv
// Golden-nonce FIFO with a serial_transmit send/busy handshake, all in hash_clk.
// Optional GOLDEN_NONCE_DEDUP_EN: drop an in_valid repeating the last accepted nonce.
module golden_nonce_queue #(
  parameter int unsigned DEPTH_LOG2   = 3,
  parameter int unsigned BUSY_TIMEOUT = 15
) (
  input  logic                  hash_clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [31:0]           in_nonce,
  input  logic                  serial_busy,
  output logic                  serial_send,
  output logic [31:0]           serial_word,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;
  localparam int unsigned PW    = DEPTH_LOG2;
  localparam int unsigned TW    = 8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  state_t        state;
  state_t        state_next;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_next;
  logic          send_next;
  logic [31:0]   word_next;
  logic          pop;
  logic          push;
  logic          drop;
  logic          dup;
  logic          full;

`ifdef GOLDEN_NONCE_DEDUP_EN
  logic [31:0] last_nonce;
  logic        last_valid;

  assign dup = in_valid && last_valid && (in_nonce == last_nonce);

  always_ff @(posedge hash_clk) begin
    if (reset) begin
      last_nonce <= '0;
      last_valid <= 1'b0;
    end else if (push) begin
      last_nonce <= in_nonce;
      last_valid <= 1'b1;
    end
  end
`else
  assign dup = 1'b0;
`endif

  assign full = (count == CW'(DEPTH));
  // A pop in the same cycle frees the slot a push into a full queue needs.
  assign push = in_valid && !dup && (!full || pop);
  assign drop = in_valid && !dup && full && !pop;

  always_comb begin
    state_next = state;
    timer_next = timer;
    send_next  = 1'b0;
    word_next  = serial_word;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if ((count != '0) && !serial_busy) begin
          pop        = 1'b1;
          word_next  = mem[rd_ptr];
          send_next  = 1'b1;
          timer_next = '0;
          state_next = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (serial_busy) begin
          state_next = WAIT_DONE;
        end else begin
          timer_next = timer + TW'(1);
          // Busy never rose: treat the word as sent and move on.
          if (timer_next == TW'(BUSY_TIMEOUT)) begin
            state_next = IDLE;
          end
        end
      end
      WAIT_DONE: begin
        if (!serial_busy) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge hash_clk) begin
    if (reset) begin
      state       <= IDLE;
      timer       <= '0;
      serial_send <= 1'b0;
      serial_word <= '0;
    end else begin
      state       <= state_next;
      timer       <= timer_next;
      serial_send <= send_next;
      serial_word <= word_next;
    end
  end

  always_ff @(posedge hash_clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Storage needs no reset; occupancy and pointers define validity.
  always_ff @(posedge hash_clk) begin
    if (push) begin
      mem[wr_ptr] <= in_nonce;
    end
  end

endmodule
